// File: rtl/out_port_uart.sv
// out_port_uart: output stage behind the CPU core. Buffers 16-bit output words
// in a FIFO and sends each word as two UART 8N1 bytes, low byte first, LSB first.
// It also reports FIFO overflow and a drained status for use after the core halts.
module out_port_uart #(
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     out_en,
  input  logic [15:0]              out_dat,
  input  logic                     is_halt,
  output logic                     tx,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     busy,
  output logic                     drained
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // FIFO state
  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;
  logic          overflow_q;

  // Transmitter state
  state_t        state_q;
  logic          tx_q;
  logic [CW-1:0] clk_cnt_q;
  logic [2:0]    bit_idx_q;
  logic          byte_idx_q;
  logic [15:0]   holder_q;

  logic       empty, push, pop, bit_end;
  logic [7:0] cur_byte;
  logic [2:0] next_bit_idx;

  assign full         = (count_q == CNT_FULL);
  assign empty        = (count_q == '0);
  assign bit_end      = (clk_cnt_q == BIT_LAST);
  assign push         = out_en && !full;
  // A word leaves the FIFO only when the transmitter enters START from IDLE or
  // from the stop bit of a word's high byte.
  assign pop          = !empty && ((state_q == IDLE) ||
                                   (state_q == STOP && bit_end && byte_idx_q));
  assign cur_byte     = byte_idx_q ? holder_q[15:8] : holder_q[7:0];
  assign next_bit_idx = bit_idx_q + 3'd1;

  // Next occupancy: a simultaneous push and pop cancel out.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (out_en && full) overflow_q <= 1'b1;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; count/pointers decide which entries are valid.
    if (push) mem[wr_ptr_q] <= out_dat;
  end

  // Transmitter FSM with registered tx; each transition sets tx for the next bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= 1'b0;
      holder_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            holder_q   <= mem[rd_ptr_q];
            byte_idx_q <= 1'b0;
            clk_cnt_q  <= '0;
            tx_q       <= 1'b0;
            state_q    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            tx_q      <= cur_byte[0];
            state_q   <= DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_idx_q <= next_bit_idx;
              tx_q      <= cur_byte[next_bit_idx];
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            if (!byte_idx_q) begin
              // High byte follows the low byte with no gap.
              byte_idx_q <= 1'b1;
              tx_q       <= 1'b0;
              state_q    <= START;
            end else if (pop) begin
              holder_q   <= mem[rd_ptr_q];
              byte_idx_q <= 1'b0;
              tx_q       <= 1'b0;
              state_q    <= START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx       = tx_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != IDLE);
  assign drained  = is_halt && empty && !busy;

endmodule

// File: tb/tb_out_port_uart.sv
// Directed self-checking bench for out_port_uart with DEPTH=4, CLKS_PER_BIT=4.
// Outputs are sampled on the falling clock edge; inputs are driven there too.
module tb_out_port_uart;

  localparam int DEPTH = 4;
  localparam int CPB   = 4;

  logic        clk;
  logic        reset;
  logic        out_en;
  logic [15:0] out_dat;
  logic        is_halt;
  logic        tx;
  logic        full;
  logic [2:0]  count;
  logic        overflow;
  logic        busy;
  logic        drained;

  int vectors     = 0;
  int miscompares = 0;

  out_port_uart #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .reset    (reset),
    .out_en   (out_en),
    .out_dat  (out_dat),
    .is_halt  (is_halt),
    .tx       (tx),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .busy     (busy),
    .drained  (drained)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level for bit slot b (0..19) of a word's two 8N1 frames.
  function automatic logic frame_bit(input logic [15:0] w, input int b);
    logic [7:0] byt;
    int         pos;
    byt = (b < 10) ? w[7:0] : w[15:8];
    pos = b % 10;
    if (pos == 0)      return 1'b0;
    else if (pos == 9) return 1'b1;
    else               return byt[pos-1];
  endfunction

  // Checks tx on every cycle of a word from cycle 'skip' onward; called at the
  // falling edge of that cycle, returns at the falling edge after the frame.
  task automatic expect_frame(input logic [15:0] w, input int skip);
    for (int i = skip; i < 20*CPB; i++) begin
      check($sformatf("tx w=%h slot%0d cyc%0d", w, i/CPB, i%CPB), tx, frame_bit(w, i/CPB));
      if (i == skip) check($sformatf("busy w=%h", w), busy, 1);
      @(negedge clk);
      out_en = 1'b0;
    end
  endtask

  initial begin
    // ---- reset state ----
    reset = 1'b1; out_en = 1'b0; out_dat = '0; is_halt = 1'b1;
    #1;
    check("rst tx", tx, 1);
    check("rst count", count, 0);
    check("rst full", full, 0);
    check("rst overflow", overflow, 0);
    check("rst busy", busy, 0);
    check("rst drained halt", drained, 1);
    is_halt = 1'b0;
    #1;
    check("rst drained nohalt", drained, 0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);

    // ---- single word 0xA55A ----
    out_en = 1'b1; out_dat = 16'hA55A;
    @(negedge clk); out_en = 1'b0;
    check("single tx before start", tx, 1);
    check("single count", count, 1);
    check("single busy before start", busy, 0);
    @(negedge clk);
    check("single count popped", count, 0);
    expect_frame(16'hA55A, 0);
    check("single busy after", busy, 0);
    check("single tx idle", tx, 1);

    // ---- back-to-back 0x0001, 0x0002, 0x0003 ----
    out_en = 1'b1; out_dat = 16'h0001;
    @(negedge clk); out_dat = 16'h0002;
    check("b2b count after w1", count, 1);
    @(negedge clk); out_dat = 16'h0003;
    check("b2b count after w2", count, 1);
    check("b2b start", tx, 0);
    @(negedge clk); out_en = 1'b0;
    check("b2b count peak", count, 2);
    expect_frame(16'h0001, 1);
    expect_frame(16'h0002, 0);
    expect_frame(16'h0003, 0);
    check("b2b busy after", busy, 0);
    check("b2b count after", count, 0);

    // ---- overflow: six pushes into DEPTH=4 ----
    out_en = 1'b1; out_dat = 16'hB001;
    @(negedge clk); out_dat = 16'hB002;
    @(negedge clk); out_dat = 16'hB003;
    check("ovf start", tx, 0);
    @(negedge clk); out_dat = 16'hB004;
    @(negedge clk); out_dat = 16'hB005;
    @(negedge clk);
    check("ovf full before w6", full, 1);
    check("ovf count before w6", count, 4);
    check("ovf flag before w6", overflow, 0);
    out_dat = 16'hB006;
    @(negedge clk); out_en = 1'b0;
    check("ovf flag", overflow, 1);
    check("ovf count after w6", count, 4);
    expect_frame(16'hB001, 4);
    expect_frame(16'hB002, 0);
    expect_frame(16'hB003, 0);
    expect_frame(16'hB004, 0);
    expect_frame(16'hB005, 0);
    check("ovf w6 dropped busy", busy, 0);
    check("ovf count drained", count, 0);
    check("ovf full drained", full, 0);
    check("ovf sticky", overflow, 1);

    // ---- asynchronous reset mid-frame ----
    out_en = 1'b1; out_dat = 16'hC0DE;
    @(negedge clk); out_dat = 16'h1234;
    @(negedge clk); out_en = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst busy before", busy, 1);
    check("midrst count before", count, 1);
    #2 reset = 1'b1;
    #1;
    check("midrst tx", tx, 1);
    check("midrst count", count, 0);
    check("midrst busy", busy, 0);
    check("midrst overflow", overflow, 0);
    check("midrst full", full, 0);
    @(negedge clk);
    check("midrst tx held", tx, 1);
    reset = 1'b0;
    @(negedge clk);
    check("midrst busy released", busy, 0);
    check("midrst tx released", tx, 1);

    // ---- pointer wrap: 10 words, two in flight at a time ----
    out_en = 1'b1; out_dat = 16'h1000;
    @(negedge clk); out_dat = 16'h1001;
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("wrap count k%0d", k), count, (k <= 8) ? 1 : 0);
      if (k + 2 <= 9) begin
        out_en  = 1'b1;
        out_dat = 16'h1000 + 16'(k + 2);
      end
      expect_frame(16'h1000 + 16'(k), 0);
    end
    check("wrap busy after", busy, 0);
    check("wrap count after", count, 0);
    check("wrap overflow", overflow, 0);

    // ---- drained with is_halt ----
    is_halt = 1'b1;
    #1;
    check("drained idle", drained, 1);
    @(negedge clk);
    out_en = 1'b1; out_dat = 16'h5AA5;
    @(negedge clk); out_en = 1'b0;
    check("drained queued", drained, 0);
    @(negedge clk);
    check("drained in flight", drained, 0);
    expect_frame(16'h5AA5, 0);
    check("drained after frame", drained, 1);
    is_halt = 1'b0;
    #1;
    check("drained halt low", drained, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
